// File: rtl/ser_bit_feeder.sv
// ---------------------------------------------------------------------------
// ser_bit_feeder
//
// Parallel-in / serial-out stage that feeds the 12-bit serial sequence
// detector. Words arrive on a valid/ready handshake and leave one bit per
// clock on x_o. When the next word is offered during the final bit of the
// current word, it is loaded without a bubble. This keeps the bit stream
// gap-free, so patterns that straddle a word boundary remain detectable.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: data_i[WIDTH-1] is sent first; 0: data_i[0] is sent first
//
// Optional feature (compile-time macro)
//   SER_FEEDER_PARITY_EN  When defined, each word's WIDTH data bits are
//                         followed by one even-parity bit. The number of bits
//                         per word (NB) becomes WIDTH+1. When undefined, no
//                         parity logic is built.
//
// Ports
//   clk        in   1      single clock, all state updates on posedge
//   reset      in   1      synchronous, active-high
//   data_i     in   WIDTH  parallel word, sampled on accept
//   valid_i    in   1      upstream word valid (held with data_i until accepted)
//   ready_o    out  1      stage can accept; accept = valid_i & ready_o at posedge
//   x_o        out  1      serial bit to detector x_i (registered)
//   x_valid_o  out  1      x_o carries a real bit this cycle (registered)
//   last_o     out  1      final bit of the current word (parity bit if enabled)
// ---------------------------------------------------------------------------
module ser_bit_feeder #(
  parameter int unsigned WIDTH     = 12,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             last_o
);

`ifdef SER_FEEDER_PARITY_EN
  localparam int unsigned NB = WIDTH + 1;
`else
  localparam int unsigned NB = WIDTH;
`endif

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // cnt value while the final bit of a word is on x_o
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef SER_FEEDER_PARITY_EN
  // cnt value while the final data bit is on x_o; the parity bit comes next
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;   // bits of the word not yet shown
  logic [CNT_W-1:0] cnt_r,   cnt_s;     // bits of the word already shown, minus one
  logic             x_r,     x_s;
  logic             x_valid_r, x_valid_s;
  logic             last_r,  last_s;
  logic             accept_s;

`ifdef SER_FEEDER_PARITY_EN
  logic             par_r,   par_s;     // parity of the word being sent

  // Even parity of a data word: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  // Bit of a word that goes out first, depending on the bit order.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    logic b;
    if (MSB_FIRST) begin
      b = w[WIDTH-1];
    end else begin
      b = w[0];
    end
    return b;
  endfunction

  // Word with its leading bit removed, so the next bit to send moves into the lead position.
  function automatic logic [WIDTH-1:0] drop_lead(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {w[WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, w[WIDTH-1:1]};
    end
    return r;
  endfunction

  // ready_o depends only on registered state, so it never combinationally
  // follows valid_i. Asserting it during the last bit allows a bubble-free
  // reload.
  assign ready_o  = (state_r == ST_IDLE) |
                    ((state_r == ST_SHIFT) & (cnt_r == CNT_LAST));
  assign accept_s = valid_i & ready_o;

  // Next-state and next-output decode for the shifter FSM.
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    cnt_s     = cnt_r;
    x_s       = 1'b0;
    x_valid_s = 1'b0;
`ifdef SER_FEEDER_PARITY_EN
    par_s     = par_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s   = ST_SHIFT;
          cnt_s     = CNT_ZERO;
          x_s       = lead_bit(data_i);
          x_valid_s = 1'b1;
          shreg_s   = drop_lead(data_i);
`ifdef SER_FEEDER_PARITY_EN
          par_s     = even_parity(data_i);
`endif
        end else begin
          state_s   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          if (accept_s) begin
            // Reload while the final bit is showing: the stream stays gap-free
            state_s   = ST_SHIFT;
            cnt_s     = CNT_ZERO;
            x_s       = lead_bit(data_i);
            x_valid_s = 1'b1;
            shreg_s   = drop_lead(data_i);
`ifdef SER_FEEDER_PARITY_EN
            par_s     = even_parity(data_i);
`endif
          end else begin
            state_s   = ST_IDLE;
            cnt_s     = CNT_ZERO;
            shreg_s   = {WIDTH{1'b0}};
          end
        end else begin
          cnt_s     = cnt_r + CNT_ONE;
          x_valid_s = 1'b1;
`ifdef SER_FEEDER_PARITY_EN
          if (cnt_r == CNT_DATA_LAST) begin
            x_s     = par_r;
          end else begin
            x_s     = lead_bit(shreg_r);
            shreg_s = drop_lead(shreg_r);
          end
`else
          x_s       = lead_bit(shreg_r);
          shreg_s   = drop_lead(shreg_r);
`endif
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        shreg_s = {WIDTH{1'b0}};
      end
    endcase

    last_s = x_valid_s & (cnt_s == CNT_LAST);
  end

  // State and output registers; reset takes priority over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      shreg_r   <= {WIDTH{1'b0}};
      cnt_r     <= CNT_ZERO;
      x_r       <= 1'b0;
      x_valid_r <= 1'b0;
      last_r    <= 1'b0;
`ifdef SER_FEEDER_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      cnt_r     <= cnt_s;
      x_r       <= x_s;
      x_valid_r <= x_valid_s;
      last_r    <= last_s;
`ifdef SER_FEEDER_PARITY_EN
      par_r     <= par_s;
`endif
    end
  end

  assign x_o       = x_r;
  assign x_valid_o = x_valid_r;
  assign last_o    = last_r;

endmodule

// File: tb/tb_ser_bit_feeder.sv
// ---------------------------------------------------------------------------
// tb_ser_bit_feeder
//
// Drives two feeders from the same stimulus: one sends MSB first and the
// other sends LSB first. A reference model keeps, for each bit order, a queue
// of the bits still to appear on x_o. The head of each queue is what that
// feeder should show this cycle.
// ---------------------------------------------------------------------------
module tb_ser_bit_feeder;

  localparam int W = 12;
`ifdef SER_FEEDER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  data_i = '0;
  logic          valid_i = 1'b0;
  logic          rdy_m, x_m, xv_m, last_m;
  logic          rdy_l, x_l, xv_l, last_l;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ser_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
    .ready_o(rdy_m), .x_o(x_m), .x_valid_o(xv_m), .last_o(last_m));

  ser_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i),
    .ready_o(rdy_l), .x_o(x_l), .x_valid_o(xv_l), .last_o(last_l));

  // ---------------- reference model ----------------
  // element = {last flag, bit}
  logic [1:0] q_msb[$];
  logic [1:0] q_lsb[$];

  function automatic bit model_ready();
    return (q_msb.size() <= 1);
  endfunction

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q_msb.push_back({(i == NB-1) ? 1'b1 : 1'b0, w[W-1-i]});
      q_lsb.push_back({(i == NB-1) ? 1'b1 : 1'b0, w[i]});
    end
    if (NB > W) begin
      q_msb.push_back({1'b1, ^w});
      q_lsb.push_back({1'b1, ^w});
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle, then settle before sampling.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] d);
    @(negedge clk);
    reset   = r;
    valid_i = v;
    data_i  = d;
    #1;
  endtask

  task automatic check_model();
    logic [1:0] hm, hl;
    hm = (q_msb.size() > 0) ? q_msb[0] : 2'b00;
    hl = (q_lsb.size() > 0) ? q_lsb[0] : 2'b00;
    chk("msb_ready",  32'(rdy_m),  32'(model_ready()));
    chk("msb_xvalid", 32'(xv_m),   32'(q_msb.size() > 0));
    chk("msb_x",      32'(x_m),    32'(hm[0]));
    chk("msb_last",   32'(last_m), 32'(hm[1]));
    chk("lsb_ready",  32'(rdy_l),  32'(model_ready()));
    chk("lsb_xvalid", 32'(xv_l),   32'(q_lsb.size() > 0));
    chk("lsb_x",      32'(x_l),    32'(hl[0]));
    chk("lsb_last",   32'(last_l), 32'(hl[1]));
  endtask

  // Clock edge, then advance the model with the inputs seen at that edge.
  task automatic advance();
    bit rdy;
    rdy = model_ready();
    @(posedge clk);
    if (reset) begin
      q_msb.delete();
      q_lsb.delete();
    end else begin
      if (q_msb.size() > 0) begin
        void'(q_msb.pop_front());
        void'(q_lsb.pop_front());
      end
      if (valid_i && rdy) push_word(data_i);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    drive(r, v, d);
    check_model();
    advance();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic         vld;
    logic [W-1:0] dat;
    bit           chk_en;
    logic         ex;
    logic         exv;
    logic         elast;
    logic         erdy;
  } vec_t;

  function automatic vec_t mkv(logic r, logic v, logic [W-1:0] d, bit c,
                               logic ex, logic exv, logic el, logic er);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = d; t.chk_en = c;
    t.ex = ex; t.exv = exv; t.elast = el; t.erdy = er;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [W-1:0] w;
    logic         b;
    bit           pend;
    bit           r;
    bit           acc;
    logic [W-1:0] pd;

    // Reset for two cycles, accept 12'hEDB, then watch it leave MSB first.
    w = 12'hEDB;
    tbl.push_back(mkv(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(1'b0, 1'b1, w,       1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < NB; i++) begin
      b = (i < W) ? w[W-1-i] : ^w;
      tbl.push_back(mkv(1'b0, 1'b0, 12'h000, 1'b1, b, 1'b1,
                        (i == NB-1) ? 1'b1 : 1'b0, (i == NB-1) ? 1'b1 : 1'b0));
    end
    tbl.push_back(mkv(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].vld, tbl[k].dat);
      if (tbl[k].chk_en) begin
        chk($sformatf("tbl_x[%0d]", k),     32'(x_m),    32'(tbl[k].ex));
        chk($sformatf("tbl_xv[%0d]", k),    32'(xv_m),   32'(tbl[k].exv));
        chk($sformatf("tbl_last[%0d]", k),  32'(last_m), 32'(tbl[k].elast));
        chk($sformatf("tbl_ready[%0d]", k), 32'(rdy_m),  32'(tbl[k].erdy));
        check_model();
      end
      advance();
    end

    // Back-to-back: valid held with 12'hEDB across two words, no bubble.
    for (int i = 0; i < 2*NB + 2; i++) begin
      step(1'b0, (i < NB + 1) ? 1'b1 : 1'b0, 12'hEDB);
    end
    step(1'b0, 1'b0, 12'h000);

    // Reset mid-word: accept 12'hFFF, reset sampled at the fifth edge after.
    step(1'b0, 1'b1, 12'hFFF);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'h000);
    step(1'b1, 1'b0, 12'h000);
    drive(1'b0, 1'b0, 12'h000);
    chk("rst_mid_xvalid", 32'(xv_m), 32'(1'b0));
    chk("rst_mid_ready",  32'(rdy_m), 32'(1'b1));
    check_model();
    advance();
    step(1'b0, 1'b0, 12'h000);

    // Reset together with valid: the word must not be taken.
    step(1'b1, 1'b1, 12'hFFF);
    drive(1'b0, 1'b0, 12'h000);
    chk("rst_valid_xvalid", 32'(xv_m), 32'(1'b0));
    check_model();
    advance();

    // 12'h001 on both orders: LSB-first shows the 1 first.
    step(1'b0, 1'b1, 12'h001);
    drive(1'b0, 1'b0, 12'h000);
    chk("lsb_first_bit", 32'(x_l), 32'(1'b1));
    chk("msb_first_bit", 32'(x_m), 32'(1'b0));
    check_model();
    advance();
    for (int i = 0; i < NB; i++) step(1'b0, 1'b0, 12'h000);

    // 12'h007: three ones, so the parity bit (when enabled) is 1.
    step(1'b0, 1'b1, 12'h007);
    for (int i = 0; i < NB + 1; i++) step(1'b0, 1'b0, 12'h000);

    // Randomized traffic: valid held with stable data until accepted.
    pend = 1'b0;
    pd   = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 9) < 7);
        pd   = W'($urandom);
      end
      r = ($urandom_range(0, 49) == 0);
      drive(r, pend, pend ? pd : 12'h000);
      check_model();
      acc = pend && !r && model_ready();
      advance();
      if (acc) pend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
